// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared types and constants for the data-memory port arbiter
package dmem_port_arbiter_pkg;
  typedef logic [31:0] word32_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} dmem_arb_state_t;
  typedef struct packed {
    logic    write;
    word32_t addr;
    word32_t wdata;
  } dmem_req_t;
  localparam int DMEM_TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter.sv
// dmem_port_arbiter_rr_arbiter: combinational round-robin pick of the first request at or after rr_ptr
module dmem_port_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);
  logic          found;
  logic [IW-1:0] j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (en && !found && req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
    gnt = found ? (NUM_REQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin sharing of one data-memory port with timeout and flush
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_write_i,
  input  word32_t [NUM_REQ-1:0]  req_addr_i,
  input  word32_t [NUM_REQ-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     resp_valid_o,
  output logic                   resp_err_o,
  output word32_t                resp_rdata_o,
  input  logic                   flush_i,
  output logic                   dmem_read_o,
  output logic                   dmem_write_o,
  output word32_t                dmem_addr_o,
  output word32_t                dmem_data_o,
  input  word32_t                dmem_rd_data_i,
  input  logic                   dmem_done_i,
  output logic                   busy_o,
  output logic                   timeout_sticky_o
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);
  dmem_arb_state_t    state;
  dmem_req_t          lat;
  logic [IW-1:0]      owner, rr_ptr, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic [CW-1:0]      wait_cnt;
  logic               discard, in_wait, done, tmo, resp;
  dmem_port_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(req_valid_i),
    .rr_ptr(rr_ptr),
    .en(state == IDLE && reset_ni),
    .gnt(gnt),
    .idx(gidx)
  );
  assign in_wait = state == WAIT;
  assign done = in_wait && dmem_done_i;
  assign tmo = in_wait && !dmem_done_i && wait_cnt == TERM;
  assign resp = (done || tmo) && !discard && !flush_i;
  assign req_ready_o = gnt;
  assign resp_valid_o = resp ? (NUM_REQ'(1) << owner) : '0;
  assign resp_err_o = resp && tmo;
  assign resp_rdata_o = resp && done && !lat.write ? dmem_rd_data_i : '0;
  assign dmem_read_o = state == ISSUE && !lat.write;
  assign dmem_write_o = state == ISSUE && lat.write;
  assign dmem_addr_o = state != IDLE ? lat.addr : '0;
  assign dmem_data_o = state != IDLE && lat.write ? lat.wdata : '0;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state <= IDLE;
      lat <= '0;
      owner <= '0;
      rr_ptr <= '0;
      wait_cnt <= '0;
      discard <= 1'b0;
      timeout_sticky_o <= 1'b0;
    end else begin
      if (state == IDLE && |gnt) begin
        state <= ISSUE;
        owner <= gidx;
        lat <= '{write: req_write_i[gidx], addr: req_addr_i[gidx], wdata: req_wdata_i[gidx]};
        rr_ptr <= gidx == IW'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
      end
      if (state == ISSUE) begin
        state <= WAIT;
        wait_cnt <= '0;
        discard <= flush_i;
      end
      if (in_wait) begin
        wait_cnt <= wait_cnt == TERM ? wait_cnt : wait_cnt + 1'b1;
        discard <= discard || flush_i;
        if (done || tmo) state <= IDLE;
        if (tmo) timeout_sticky_o <= 1'b1;
      end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench for the data-memory port arbiter
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;
  typedef struct {
    logic [1:0] vld;
    logic       err;
    word32_t    rdata;
  } exp_t;
  logic clk_i, reset_ni, flush_i, dmem_done_i;
  logic [1:0] req_valid_i, req_write_i, req_ready_o, resp_valid_o;
  word32_t [1:0] req_addr_i, req_wdata_i;
  logic resp_err_o, dmem_read_o, dmem_write_o, busy_o, timeout_sticky_o;
  word32_t resp_rdata_o, dmem_addr_o, dmem_data_o, dmem_rd_data_i;
  logic mem_done, extra_done, mem_en;
  int mem_lat, mem_cnt, n_cmp, n_err;
  exp_t sb[$];
  exp_t mon_e;
  dmem_port_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .req_valid_i(req_valid_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
    .flush_i(flush_i), .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
    .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o), .dmem_rd_data_i(dmem_rd_data_i),
    .dmem_done_i(dmem_done_i), .busy_o(busy_o), .timeout_sticky_o(timeout_sticky_o)
  );
  assign dmem_done_i = mem_done || extra_done;
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk_i) begin
    mem_done = 1'b0;
    dmem_rd_data_i = 32'hBAD0_0000;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0 && mem_en) begin
        mem_done = 1'b1;
        dmem_rd_data_i = dmem_addr_o == 32'h100 ? 32'hDEADBEEF : ~dmem_addr_o;
      end
    end
    #1;
    if (dmem_read_o || dmem_write_o) mem_cnt = mem_lat;
  end
  always @(negedge clk_i) begin
    #2;
    if (|resp_valid_o) begin
      if (sb.size() == 0) chk("resp_unexpected", 32'(resp_valid_o), 32'h0);
      else begin
        mon_e = sb.pop_front();
        chk("resp_idx", 32'(resp_valid_o), 32'(mon_e.vld));
        chk("resp_err", 32'(resp_err_o), 32'(mon_e.err));
        chk("resp_rdata", resp_rdata_o, mon_e.rdata);
      end
    end
  end
  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_ni = 1'b0;
    req_valid_i = '0;
    req_write_i = '0;
    req_addr_i = '0;
    req_wdata_i = '0;
    flush_i = 1'b0;
    extra_done = 1'b0;
    mem_en = 1'b1;
    mem_lat = 1;
    mem_cnt = 0;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    reset_ni = 1'b1;
    @(negedge clk_i);
    mem_lat = 2;
    req_valid_i = 2'b01;
    req_addr_i[0] = 32'h100;
    #1 chk("load_ready", 32'(req_ready_o), 32'h1);
    sb.push_back('{vld: 2'b01, err: 1'b0, rdata: 32'hDEADBEEF});
    @(negedge clk_i);
    req_valid_i = '0;
    req_addr_i[0] = 32'h999;
    #1 chk("load_strobe", 32'(dmem_read_o), 32'h1);
    chk("load_addr", dmem_addr_o, 32'h100);
    chk("load_ready_off", 32'(req_ready_o), 32'h0);
    @(negedge clk_i);
    #1 chk("load_strobe_off", 32'(dmem_read_o), 32'h0);
    chk("load_addr_hold", dmem_addr_o, 32'h100);
    chk("load_no_early_resp", 32'(resp_valid_o), 32'h0);
    @(negedge clk_i);
    #1 chk("load_resp_t3", 32'(resp_valid_o), 32'h1);
    chk("load_rdata_t3", resp_rdata_o, 32'hDEADBEEF);
    @(negedge clk_i);
    #1 chk("load_idle_t4", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    reset_ni = 1'b0;
    mem_lat = 1;
    req_valid_i = 2'b11;
    req_addr_i[0] = 32'h200;
    req_addr_i[1] = 32'h300;
    #1 chk("rst_ready_gated", 32'(req_ready_o), 32'h0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    for (int g = 0; g < 4; g++) begin
      if (g > 0) @(negedge clk_i);
      #1 chk("cont_ready", 32'(req_ready_o), 32'(2'b01 << (g % 2)));
      sb.push_back('{vld: 2'(2'b01 << (g % 2)), err: 1'b0, rdata: ~(g % 2 == 1 ? 32'h300 : 32'h200)});
      @(negedge clk_i);
      #1 chk("cont_addr", dmem_addr_o, g % 2 == 1 ? 32'h300 : 32'h200);
      chk("cont_strobe", 32'(dmem_read_o), 32'h1);
      @(negedge clk_i);
    end
    @(negedge clk_i);
    req_valid_i = 2'b10;
    req_write_i = 2'b10;
    req_addr_i[1] = 32'h40;
    req_wdata_i[1] = 32'h12345678;
    #1 chk("store_ready", 32'(req_ready_o), 32'h2);
    sb.push_back('{vld: 2'b10, err: 1'b0, rdata: 32'h0});
    @(negedge clk_i);
    req_valid_i = '0;
    req_wdata_i[1] = '0;
    #1 chk("store_write", 32'(dmem_write_o), 32'h1);
    chk("store_no_read", 32'(dmem_read_o), 32'h0);
    chk("store_addr", dmem_addr_o, 32'h40);
    chk("store_data", dmem_data_o, 32'h12345678);
    @(negedge clk_i);
    #1 chk("store_write_off", 32'(dmem_write_o), 32'h0);
    chk("store_data_hold", dmem_data_o, 32'h12345678);
    @(negedge clk_i);
    #1 chk("store_idle", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    req_valid_i = 2'b11;
    req_write_i = '0;
    req_addr_i[0] = 32'h500;
    req_addr_i[1] = 32'h600;
    mem_lat = 3;
    #1 chk("flush_ready", 32'(req_ready_o), 32'h1);
    @(negedge clk_i);
    req_valid_i = 2'b10;
    @(negedge clk_i);
    flush_i = 1'b1;
    #1 chk("flush_no_resp", 32'(resp_valid_o), 32'h0);
    @(negedge clk_i);
    flush_i = 1'b0;
    @(negedge clk_i);
    #1 chk("flush_done_suppressed", 32'(resp_valid_o), 32'h0);
    chk("flush_busy", 32'(busy_o), 32'h1);
    chk("flush_no_grant_wait", 32'(req_ready_o), 32'h0);
    @(negedge clk_i);
    mem_lat = 1;
    #1 chk("flush_next_grant", 32'(req_ready_o), 32'h2);
    sb.push_back('{vld: 2'b10, err: 1'b0, rdata: ~32'h600});
    @(negedge clk_i);
    req_valid_i = '0;
    #1 chk("flush_next_addr", dmem_addr_o, 32'h600);
    @(negedge clk_i);
    @(negedge clk_i);
    #1 chk("flush_next_idle", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    mem_en = 1'b0;
    req_valid_i = 2'b01;
    req_addr_i[0] = 32'h700;
    #1 chk("tmo_ready", 32'(req_ready_o), 32'h1);
    sb.push_back('{vld: 2'b01, err: 1'b1, rdata: 32'h0});
    @(negedge clk_i);
    req_valid_i = '0;
    repeat (6) @(negedge clk_i);
    @(negedge clk_i);
    #1 chk("tmo_not_early", 32'(resp_valid_o), 32'h0);
    chk("tmo_sticky_pre", 32'(timeout_sticky_o), 32'h0);
    @(negedge clk_i);
    #1 chk("tmo_resp", 32'(resp_valid_o), 32'h1);
    chk("tmo_err", 32'(resp_err_o), 32'h1);
    @(negedge clk_i);
    extra_done = 1'b1;
    #1 chk("tmo_sticky", 32'(timeout_sticky_o), 32'h1);
    chk("tmo_idle", 32'(busy_o), 32'h0);
    chk("tmo_late_done", 32'(resp_valid_o), 32'h0);
    @(negedge clk_i);
    extra_done = 1'b0;
    mem_en = 1'b1;
    mem_lat = 4;
    req_valid_i = 2'b10;
    req_addr_i[1] = 32'h800;
    #1 chk("arst_ready", 32'(req_ready_o), 32'h2);
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    #1 chk("arst_busy_pre", 32'(busy_o), 32'h1);
    #2 reset_ni = 1'b0;
    req_valid_i = 2'b11;
    req_addr_i[0] = 32'h900;
    #1 chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_addr", dmem_addr_o, 32'h0);
    chk("arst_ready_out", 32'(req_ready_o), 32'h0);
    chk("arst_strobes", 32'({dmem_read_o, dmem_write_o}), 32'h0);
    chk("arst_resp", 32'({resp_valid_o, resp_err_o}), 32'h0);
    chk("arst_rdata", resp_rdata_o, 32'h0);
    chk("arst_sticky", 32'(timeout_sticky_o), 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    mem_lat = 1;
    #1 chk("arst_first_grant", 32'(req_ready_o), 32'h1);
    sb.push_back('{vld: 2'b01, err: 1'b0, rdata: ~32'h900});
    @(negedge clk_i);
    req_valid_i = '0;
    #1 chk("arst_issue_addr", dmem_addr_o, 32'h900);
    chk("arst_stale_done_ignored", 32'(resp_valid_o), 32'h0);
    @(negedge clk_i);
    #1 chk("arst_resp_after", 32'(resp_valid_o), 32'h1);
    @(negedge clk_i);
    #1 chk("arst_idle", 32'(busy_o), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between NUM_REQ requesters. Requester 0 is the load/store read-write unit; requester 1 is the store-buffer drain / debug access port.
- Accepts one request at a time with a round-robin grant and latches it.
- Drives a one-cycle dmem_read_o/dmem_write_o pulse, then waits for dmem_done_i and routes the completion and read data back to the owning requester.
- Adds a completion timeout and a flush that discards in-flight load results.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before a forced abort.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  request pending; requester holds it and its payload until req_ready_o.
- req_write_i  in  NUM_REQ  1 = store, 0 = load.
- req_addr_i  in  NUM_REQ x word32_t  effective address.
- req_wdata_i  in  NUM_REQ x word32_t  store data.
- req_ready_o  out  NUM_REQ  one-hot acceptance pulse.
- resp_valid_o  out  NUM_REQ  one-hot completion pulse.
- resp_err_o  out  1  qualifies resp_valid_o: access timed out.
- resp_rdata_o  out  word32_t  load data, valid with resp_valid_o on a load.
- flush_i  in  1  discard the response of the in-flight access.
- dmem_read_o  out  1  one-cycle read strobe.
- dmem_write_o  out  1  one-cycle write strobe.
- dmem_addr_o  out  word32_t  memory address.
- dmem_data_o  out  word32_t  store data.
- dmem_rd_data_i  in  word32_t  memory read data.
- dmem_done_i  in  1  access complete.
- busy_o  out  1  state != IDLE.
- timeout_sticky_o  out  1  a timeout has occurred since reset.

Behaviour:
- Reset (async, reset_ni = 0):
  - state = IDLE, rr_ptr = 0, counters = 0, latched request cleared.
  - All outputs 0; address and data outputs 0.
  - Reset mid-access abandons the access with no response. Any dmem_done_i afterwards is ignored.
- FSM has states IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid_i is set, grant the first valid index at or after rr_ptr, in increasing index with wrap.
  - Drive req_ready_o[g] = 1 combinationally in that cycle.
  - Latch g, write, addr, wdata. Set rr_ptr = (g+1) mod NUM_REQ. Go to ISSUE.
  - No valid request: stay in IDLE, all ready outputs 0.
- ISSUE (exactly 1 cycle):
  - Drive dmem_read_o or dmem_write_o = 1 from the latched op.
  - Drive dmem_addr_o, plus dmem_data_o on a store.
  - Clear wait_cnt and the discard flag. Go to WAIT.
- WAIT:
  - Strobes are 0. Address and data are held at the latched values.
  - wait_cnt increments each cycle.
  - On dmem_done_i: pulse resp_valid_o[g] for that same cycle. resp_rdata_o = dmem_rd_data_i on a load, 0 on a store. resp_err_o = 0. Go to IDLE.
  - A new grant is evaluated the following cycle, giving minimum throughput of 1 access per 3 cycles plus memory latency.
  - If wait_cnt reaches TIMEOUT_CYCLES-1 without done: pulse resp_valid_o[g] with resp_err_o = 1 and rdata 0, set timeout_sticky_o, go to IDLE.
- Flush:
  - flush_i in ISSUE or WAIT sets the discard flag.
  - The access still completes on the memory side (a store still writes). The resp_valid_o pulse is suppressed and the FSM still returns to IDLE on done or timeout.
  - flush_i in IDLE has no effect.
  - Flush and done in the same cycle: response suppressed.
- dmem_done_i in IDLE or ISSUE is ignored.
- wait_cnt width is $clog2(TIMEOUT_CYCLES)+1 and saturates at terminal count.
- Requester payload may change after req_ready_o; only latched values drive memory.
- Timing rule: req_ready_o depends combinationally only on req_valid_i and state. No combinational path from dmem_done_i to req_ready_o.

Decomposition:
- In data_types:
  - word32_t (existing).
  - New enum dmem_arb_state_t {IDLE, ISSUE, WAIT}.
  - New packed struct dmem_req_t {write, addr, wdata}.
  - Constant DMEM_TIMEOUT_DEFAULT = 64.
- One sub-module, rr_arbiter: parameterized NUM_REQ. Inputs req vector, rr_ptr, enable. Outputs one-hot grant and encoded index. Purely combinational; rr_ptr is stored in the parent.

Test Plan:
- Single load:
  - Stimulus: req0 load at addr 0x100; memory returns 0xDEADBEEF with done 2 cycles after the strobe.
  - Required: ready0 at T0; dmem_read_o with addr 0x100 at T1 only; resp_valid_o[0] with rdata 0xDEADBEEF at T3; busy_o low at T4.
- Contention:
  - Stimulus: req0 and req1 valid continuously from reset, all accesses done 1 cycle after the strobe.
  - Required: grants alternate 0,1,0,1. Each requester receives exactly one response per grant, to the correct index.
- Store path:
  - Stimulus: req1 store, addr 0x40, data 0x12345678.
  - Required: dmem_write_o = 1 for exactly 1 cycle with those values; resp_valid_o[1] with rdata 0.
- Flush:
  - Stimulus: load granted, flush_i in the cycle after ISSUE, done arrives later.
  - Required: no resp_valid_o pulse; FSM returns to IDLE; the next pending request is then granted normally.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8, done never asserted.
  - Required: resp_valid_o[g] with resp_err_o = 1 in the 8th WAIT cycle; timeout_sticky_o = 1; a late done is ignored.
- Async reset mid-WAIT:
  - Stimulus: reset_ni low between clock edges.
  - Required: all outputs 0 immediately; after release the FSM is in IDLE with rr_ptr 0, and the first grant goes to req0 when both requesters are valid.
